// File: rtl/alu_resp_checker.sv
// alu_resp_checker: recomputes ALU results in a two-stage pipe, counts pass/fail, captures first mismatch
module alu_resp_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_out,
  input  logic             in_c,
  input  logic             in_z,
  input  logic             in_n,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_valid,
  output logic [2:0]       err_sel,
  output logic [WIDTH+2:0] err_got,
  output logic [WIDTH+2:0] err_exp
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic in_ready_q, halt_q;
  logic s1_v_q, s2_v_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0] s1_sel_q, s2_sel_q;
  logic [WIDTH+2:0] s1_got_q, s2_got_q, s2_exp_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic err_v_q;
  logic [2:0] err_sel_q;
  logic [WIDTH+2:0] err_got_q, err_exp_q;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] res;
  logic cy, mis, halt_now, xfer;
  logic [WIDTH+2:0] exp_w;
  assign sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign dif = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + (WIDTH+1)'(1);
  always_comb begin
    res = '0;
    case (s1_sel_q)
      3'd0: res = sum[WIDTH-1:0];
      3'd1: res = dif[WIDTH-1:0];
      3'd2: res = s1_a_q & s1_b_q;
      3'd3: res = s1_a_q | s1_b_q;
      3'd4: res = s1_a_q ^ s1_b_q;
      3'd5: res = ~(s1_a_q | s1_b_q);
      3'd6: res = s1_a_q << s1_b_q[4:0];
      default: res = s1_a_q >> s1_b_q[4:0];
    endcase
  end
  assign cy = s1_sel_q == 3'd0 ? sum[WIDTH] : s1_sel_q == 3'd1 ? dif[WIDTH] : 1'b0;
  assign exp_w = {res, cy, res == '0, res[WIDTH-1]};
  assign mis = s2_v_q && (s2_got_q != s2_exp_q);
  // A halting mismatch squashes both stages at the same edge that counts it
  assign halt_now = STOP_ON_ERR && mis && state_q == RUN && !start;
  assign xfer = in_valid && in_ready_q && !start && !halt_now;
  always_comb begin
    state_d = state_q;
    if (start) state_d = RUN;
    else if (state_q == RUN) state_d = halt_q ? HALT : stop ? DRAIN : RUN;
    else if (state_q == DRAIN) state_d = s1_v_q ? DRAIN : IDLE;
    else if (state_q == HALT) state_d = stop ? IDLE : HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      halt_q <= 1'b0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
      err_v_q <= 1'b0;
      err_sel_q <= '0;
      err_got_q <= '0;
      err_exp_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= state_d == RUN && !halt_now;
      halt_q <= halt_now;
      s1_v_q <= xfer;
      s2_v_q <= s1_v_q && !start && !halt_now;
      if (start) begin
        pass_q <= '0;
        fail_q <= '0;
        err_v_q <= 1'b0;
        err_sel_q <= '0;
        err_got_q <= '0;
        err_exp_q <= '0;
      end else if (s2_v_q) begin
        if (mis) fail_q <= fail_q + CNT_W'(fail_q != '1);
        else pass_q <= pass_q + CNT_W'(pass_q != '1);
        if (mis && !err_v_q) begin
          err_v_q <= 1'b1;
          err_sel_q <= s2_sel_q;
          err_got_q <= s2_got_q;
          err_exp_q <= s2_exp_q;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_a_q <= in_a;
      s1_b_q <= in_b;
      s1_sel_q <= in_sel;
      s1_got_q <= {in_out, in_c, in_z, in_n};
    end
    if (s1_v_q) begin
      s2_sel_q <= s1_sel_q;
      s2_got_q <= s1_got_q;
      s2_exp_q <= exp_w;
    end
  end
  assign in_ready = in_ready_q;
  assign busy = state_q != IDLE;
  assign halted = state_q == HALT;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err_valid = err_v_q;
  assign err_sel = err_sel_q;
  assign err_got = err_got_q;
  assign err_exp = err_exp_q;
endmodule

// File: tb/tb_alu_resp_checker.sv
// tb_alu_resp_checker: directed scoreboard bench over three parameterisations sharing one stimulus bus
module tb_alu_resp_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [31:0] in_a = '0, in_b = '0, in_out = '0;
  logic [2:0] in_sel = '0;
  logic in_c = 1'b0, in_z = 1'b0, in_n = 1'b0;
  logic rdy0, busy0, halt0, ev0, rdy1, busy1, halt1, ev1, rdy2, busy2, halt2, ev2;
  logic [15:0] pass0, fail0, pass1, fail1;
  logic [3:0] pass2, fail2;
  logic [2:0] esel0, esel1, esel2;
  logic [34:0] egot0, eexp0, egot1, eexp1, egot2, eexp2;
  logic [34:0] rsp [8];
  bit exp_q [$];
  int vectors = 0, miscompares = 0;
  logic [15:0] prev_p = '0, prev_f = '0;
  bit e;
  always #5 clk = ~clk;
  alu_resp_checker u0 (.clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_out(in_out), .in_c(in_c), .in_z(in_z), .in_n(in_n),
    .busy(busy0), .halted(halt0), .pass_cnt(pass0), .fail_cnt(fail0), .err_valid(ev0), .err_sel(esel0),
    .err_got(egot0), .err_exp(eexp0));
  alu_resp_checker #(.STOP_ON_ERR(1'b1)) u1 (.clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(rdy1), .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_out(in_out), .in_c(in_c), .in_z(in_z),
    .in_n(in_n), .busy(busy1), .halted(halt1), .pass_cnt(pass1), .fail_cnt(fail1), .err_valid(ev1),
    .err_sel(esel1), .err_got(egot1), .err_exp(eexp1));
  alu_resp_checker #(.CNT_W(4)) u2 (.clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(rdy2), .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_out(in_out), .in_c(in_c), .in_z(in_z),
    .in_n(in_n), .busy(busy2), .halted(halt2), .pass_cnt(pass2), .fail_cnt(fail2), .err_valid(ev2),
    .err_sel(esel2), .err_got(egot2), .err_exp(eexp2));
  // Scoreboard: every counter step of u0 pops one expected verdict (1 = mismatch)
  always @(negedge clk) begin
    if (!rst && (pass0 == prev_p + 16'd1 || fail0 == prev_f + 16'd1)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $error("FAIL sb_underflow got=unexpected counter step exp=none");
      end else begin
        e = exp_q.pop_front();
        assert ((fail0 == prev_f + 16'd1) === e) else begin
          miscompares++;
          $error("FAIL sb_verdict got=%0b exp=%0b", fail0 == prev_f + 16'd1, e);
        end
      end
    end
    prev_p = pass0;
    prev_f = fail0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input int sel, input logic [34:0] r, input bit bad);
    in_valid = 1'b1;
    in_a = 32'hFFFF_FFFF;
    in_b = 32'h8000_0001;
    in_sel = 3'(sel);
    {in_out, in_c, in_z, in_n} = r;
    exp_q.push_back(bad);
    tick();
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    int n;
    rsp = '{{32'h8000_0000, 3'b101}, {32'h7FFF_FFFE, 3'b100}, {32'h8000_0001, 3'b001}, {32'hFFFF_FFFF, 3'b001},
            {32'h7FFF_FFFE, 3'b000}, {32'h0000_0000, 3'b010}, {32'hFFFF_FFFE, 3'b001}, {32'h7FFF_FFFF, 3'b000}};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_halted", halt0, 0);
    chk("rst_err_valid", ev0, 0);
    chk("rst_counts", {pass0, fail0}, 0);
    chk("rst_err_fields", {esel0, egot0, eexp0}, 0);
    pulse_start();
    chk("run_ready", rdy0, 1);
    chk("run_busy", busy0, 1);
    for (int i = 0; i < 8; i++) drive(i, rsp[i], 1'b0);
    idle(3);
    chk("clean_pass", pass0, 8);
    chk("clean_fail", fail0, 0);
    chk("clean_err_valid", ev0, 0);
    chk("clean_sb_empty", exp_q.size(), 0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      drive(i, i == 1 ? rsp[i] ^ 35'h4 : rsp[i], i == 1);
      if (i == 2) chk("err_valid_k1", ev0, 0);
      if (i == 3) chk("err_valid_k2", ev0, 1);
    end
    idle(3);
    chk("badc_pass", pass0, 7);
    chk("badc_fail", fail0, 1);
    chk("badc_err_sel", esel0, 3'b001);
    chk("badc_err_got", egot0, {32'h7FFF_FFFE, 3'b000});
    chk("badc_err_exp", eexp0, {32'h7FFF_FFFE, 3'b100});
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      drive(i, i == 2 ? rsp[i] ^ 35'h1 : rsp[i], i == 2);
      if (i == 4) begin
        chk("soe_ready_low", rdy1, 0);
        chk("soe_halted_k2", halt1, 0);
      end
      if (i == 5) chk("soe_halted_k3", halt1, 1);
    end
    idle(3);
    chk("soe_pass", pass1, 2);
    chk("soe_fail", fail1, 1);
    chk("soe_ready_held", rdy1, 0);
    pulse_start();
    chk("soe_restart_counts", {pass1, fail1}, 0);
    chk("soe_restart_ready", rdy1, 1);
    chk("soe_restart_halted", halt1, 0);
    drive(0, rsp[0], 1'b0);
    stop = 1'b1;
    drive(1, rsp[1], 1'b0);
    stop = 1'b0;
    in_valid = 1'b0;
    n = 0;
    while (busy0 && n < 6) begin
      tick();
      n++;
    end
    chk("stop_busy_fall", n <= 3 && !busy0, 1);
    chk("stop_pass", pass0, 2);
    chk("stop_ready", rdy0, 0);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", busy0, 1);
    chk("start_stop_ready", rdy0, 1);
    for (int i = 0; i < 20; i++) drive(i % 8, rsp[i % 8], 1'b0);
    idle(3);
    chk("sat_pass", pass2, 4'hF);
    chk("sat_fail", fail2, 0);
    chk("wide_pass", pass0, 20);
    chk("sat_sb_empty", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) drive(i, rsp[i], 1'b0);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("mrst_ready", rdy0, 0);
    chk("mrst_busy", busy0, 0);
    chk("mrst_counts", {pass0, fail0, pass2}, 0);
    chk("mrst_err", {ev0, esel0, egot0, eexp0}, 0);
    rst = 1'b0;
    idle(3);
    chk("mrst_lost", {pass0, fail0, busy0}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
